// File: rtl/l1d_data_ram_arbiter.sv
// L1D data-RAM arbiter: refill/evict bursts and core hits share one data-RAM pipe.
// Define L1D_DATA_RAM_ARB_STARVE_EN to enable core anti-starvation promotion.

package l1d_data_ram_arbiter_pkg;

    typedef struct packed {
        logic        wr;
        logic [1:0]  way;
        logic [7:0]  idx;
        logic [31:0] wdata;
    } pack_l1d_data_ram_req;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_REFILL = 2'd1,
        SRC_EVICT  = 2'd2,
        SRC_CORE   = 2'd3
    } gnt_src_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL_BURST,
        ST_EVICT_BURST
    } state_e;

endpackage

module l1d_data_ram_arbiter
    import l1d_data_ram_arbiter_pkg::*;
#(
    parameter int REFILL_BEATS = 4,
    parameter int EVICT_BEATS  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 refill_req_vld,
    output logic                 refill_req_rdy,
    input  pack_l1d_data_ram_req refill_req_pld,
    input  logic                 evict_req_vld,
    output logic                 evict_req_rdy,
    input  pack_l1d_data_ram_req evict_req_pld,
    input  logic                 evict_req_id_in,
    input  logic                 core_req_vld,
    output logic                 core_req_rdy,
    input  pack_l1d_data_ram_req core_req_pld,
    output logic                 data_ram_req_vld,
    input  logic                 data_ram_req_rdy,
    output pack_l1d_data_ram_req data_ram_req_pld,
    output logic                 evict_req_id,
    output logic [1:0]           data_ram_gnt_src
);

    localparam logic [4:0] LP_REFILL_LAST = 5'(REFILL_BEATS - 1);
    localparam logic [4:0] LP_EVICT_LAST  = 5'(EVICT_BEATS - 1);

    if (REFILL_BEATS < 1 || REFILL_BEATS > 16 || EVICT_BEATS < 1 || EVICT_BEATS > 16 ||
        STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_params
        $error("l1d_data_ram_arbiter: parameter out of legal range");
    end

    state_e     r_state;
    state_e     w_state_nxt;
    logic [4:0] r_beat_cnt;
    logic [4:0] w_beat_cnt_nxt;
    gnt_src_e   w_sel;
    logic       w_xfer;
    logic       w_promote;

    assign w_xfer = data_ram_req_vld & data_ram_req_rdy;

`ifdef L1D_DATA_RAM_ARB_STARVE_EN
    localparam logic [7:0] LP_STARVE_LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] r_starve_cnt;
    logic       w_core_xfer;

    assign w_core_xfer = w_xfer && (w_sel == SRC_CORE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 8'd0;
        end else if (!core_req_vld || w_core_xfer) begin
            r_starve_cnt <= 8'd0;
        end else if (r_starve_cnt != LP_STARVE_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    // Promotion only matters in IDLE; bursts are never preempted.
    assign w_promote = (r_starve_cnt == LP_STARVE_LIMIT);
`else
    assign w_promote = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= 5'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_sel            = SRC_NONE;
        w_state_nxt      = r_state;
        w_beat_cnt_nxt   = r_beat_cnt;
        data_ram_req_vld = 1'b0;
        data_ram_req_pld = '0;
        evict_req_id     = 1'b0;
        refill_req_rdy   = 1'b0;
        evict_req_rdy    = 1'b0;
        core_req_rdy     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_promote && core_req_vld) w_sel = SRC_CORE;
                else if (refill_req_vld)       w_sel = SRC_REFILL;
                else if (evict_req_vld)        w_sel = SRC_EVICT;
                else if (core_req_vld)         w_sel = SRC_CORE;
            end
            ST_REFILL_BURST: if (refill_req_vld) w_sel = SRC_REFILL;
            ST_EVICT_BURST:  if (evict_req_vld)  w_sel = SRC_EVICT;
            default:         w_sel = SRC_NONE;
        endcase

        case (w_sel)
            SRC_REFILL: begin
                data_ram_req_vld = 1'b1;
                data_ram_req_pld = refill_req_pld;
                refill_req_rdy   = data_ram_req_rdy;
            end
            SRC_EVICT: begin
                data_ram_req_vld = 1'b1;
                data_ram_req_pld = evict_req_pld;
                evict_req_id     = evict_req_id_in;
                evict_req_rdy    = data_ram_req_rdy;
            end
            SRC_CORE: begin
                data_ram_req_vld = 1'b1;
                data_ram_req_pld = core_req_pld;
                core_req_rdy     = data_ram_req_rdy;
            end
            default: ;
        endcase

        if (w_xfer) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel == SRC_REFILL && REFILL_BEATS > 1) begin
                        w_state_nxt    = ST_REFILL_BURST;
                        w_beat_cnt_nxt = 5'd1;
                    end else if (w_sel == SRC_EVICT && EVICT_BEATS > 1) begin
                        w_state_nxt    = ST_EVICT_BURST;
                        w_beat_cnt_nxt = 5'd1;
                    end
                end
                ST_REFILL_BURST: begin
                    if (r_beat_cnt == LP_REFILL_LAST) begin
                        w_state_nxt    = ST_IDLE;
                        w_beat_cnt_nxt = 5'd0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 5'd1;
                    end
                end
                ST_EVICT_BURST: begin
                    if (r_beat_cnt == LP_EVICT_LAST) begin
                        w_state_nxt    = ST_IDLE;
                        w_beat_cnt_nxt = 5'd0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 5'd1;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_beat_cnt_nxt = 5'd0;
                end
            endcase
        end
    end

    assign data_ram_gnt_src = w_sel;

endmodule

// File: tb/tb_l1d_data_ram_arbiter.sv
// Directed bench for l1d_data_ram_arbiter (REFILL_BEATS=4, EVICT_BEATS=4, STARVE_LIMIT=8).
// Expectations follow L1D_DATA_RAM_ARB_STARVE_EN when the bench is built with it defined.

module tb_l1d_data_ram_arbiter;
    import l1d_data_ram_arbiter_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 refill_req_vld;
    logic                 refill_req_rdy;
    pack_l1d_data_ram_req refill_req_pld;
    logic                 evict_req_vld;
    logic                 evict_req_rdy;
    pack_l1d_data_ram_req evict_req_pld;
    logic                 evict_req_id_in;
    logic                 core_req_vld;
    logic                 core_req_rdy;
    pack_l1d_data_ram_req core_req_pld;
    logic                 data_ram_req_vld;
    logic                 data_ram_req_rdy;
    pack_l1d_data_ram_req data_ram_req_pld;
    logic                 evict_req_id;
    logic [1:0]           data_ram_gnt_src;

    int n_tests = 0;
    int n_fail  = 0;

    l1d_data_ram_arbiter #(
        .REFILL_BEATS(4),
        .EVICT_BEATS (4),
        .STARVE_LIMIT(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .refill_req_vld  (refill_req_vld),
        .refill_req_rdy  (refill_req_rdy),
        .refill_req_pld  (refill_req_pld),
        .evict_req_vld   (evict_req_vld),
        .evict_req_rdy   (evict_req_rdy),
        .evict_req_pld   (evict_req_pld),
        .evict_req_id_in (evict_req_id_in),
        .core_req_vld    (core_req_vld),
        .core_req_rdy    (core_req_rdy),
        .core_req_pld    (core_req_pld),
        .data_ram_req_vld(data_ram_req_vld),
        .data_ram_req_rdy(data_ram_req_rdy),
        .data_ram_req_pld(data_ram_req_pld),
        .evict_req_id    (evict_req_id),
        .data_ram_gnt_src(data_ram_gnt_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pack_l1d_data_ram_req mk(input logic [7:0] idx, input logic [31:0] d);
        pack_l1d_data_ram_req p;
        p.wr    = 1'b1;
        p.way   = idx[1:0];
        p.idx   = idx;
        p.wdata = d;
        return p;
    endfunction

    task automatic idle_inputs();
        refill_req_vld   = 1'b0;
        evict_req_vld    = 1'b0;
        core_req_vld     = 1'b0;
        refill_req_pld   = '0;
        evict_req_pld    = '0;
        core_req_pld     = '0;
        evict_req_id_in  = 1'b0;
        data_ram_req_rdy = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk); #1;
        n_tests++;
        if ({data_ram_req_vld, refill_req_rdy, evict_req_rdy, core_req_rdy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_vld_rdy: got %b expected 0000",
                     {data_ram_req_vld, refill_req_rdy, evict_req_rdy, core_req_rdy});
        end
        n_tests++;
        if (data_ram_gnt_src !== 2'd0 || data_ram_req_pld !== '0 || evict_req_id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_src_pld: src %0d pld %h id %b expected 0/0/0",
                     data_ram_gnt_src, data_ram_req_pld, evict_req_id);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_refill_burst();
        pack_l1d_data_ram_req exp;
        @(negedge clk);
        core_req_vld   = 1'b1;
        core_req_pld   = mk(8'hC0, 32'hC0C0_0001);
        refill_req_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp            = mk(8'(8'h10 + i), 32'hAAAA_0000 + 32'(i));
            refill_req_pld = exp;
            #1;
            n_tests++;
            if (data_ram_gnt_src !== 2'd1 || refill_req_rdy !== 1'b1 || core_req_rdy !== 1'b0 ||
                data_ram_req_pld !== exp) begin
                n_fail++;
                $display("FAIL refill_beat%0d: src %0d rrdy %b crdy %b pld %h expected 1/1/0/%h",
                         i, data_ram_gnt_src, refill_req_rdy, core_req_rdy, data_ram_req_pld, exp);
            end
            @(negedge clk);
        end
        refill_req_vld = 1'b0;
        #1;
        n_tests++;
        if (data_ram_gnt_src !== 2'd3 || core_req_rdy !== 1'b1 || data_ram_req_pld !== core_req_pld) begin
            n_fail++;
            $display("FAIL refill_then_core: src %0d crdy %b pld %h expected 3/1/%h",
                     data_ram_gnt_src, core_req_rdy, data_ram_req_pld, core_req_pld);
        end
        @(negedge clk);
        core_req_vld = 1'b0;
        #1;
        n_tests++;
        if (data_ram_gnt_src !== 2'd0 || data_ram_req_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL refill_drained: src %0d vld %b expected 0/0", data_ram_gnt_src, data_ram_req_vld);
        end
    endtask

    task automatic test_refill_bubble();
        pack_l1d_data_ram_req exp;
        @(negedge clk);
        refill_req_vld  = 1'b1;
        refill_req_pld  = mk(8'h20, 32'hBBBB_0000);
        evict_req_vld   = 1'b1;
        evict_req_pld   = mk(8'h40, 32'hEEEE_0000);
        evict_req_id_in = 1'b1;
        #1;
        n_tests++;
        if (data_ram_gnt_src !== 2'd1) begin
            n_fail++;
            $display("FAIL bubble_beat1: src %0d expected 1", data_ram_gnt_src);
        end
        @(negedge clk);
        refill_req_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (data_ram_req_vld !== 1'b0 || data_ram_gnt_src !== 2'd0 || evict_req_rdy !== 1'b0 ||
                data_ram_req_pld !== '0) begin
                n_fail++;
                $display("FAIL bubble_gap%0d: vld %b src %0d erdy %b pld %h expected 0/0/0/0",
                         i, data_ram_req_vld, data_ram_gnt_src, evict_req_rdy, data_ram_req_pld);
            end
            @(negedge clk);
        end
        refill_req_vld = 1'b1;
        for (int i = 1; i < 4; i++) begin
            refill_req_pld = mk(8'(8'h20 + i), 32'hBBBB_0000 + 32'(i));
            #1;
            n_tests++;
            if (data_ram_gnt_src !== 2'd1 || evict_req_rdy !== 1'b0 || evict_req_id !== 1'b0) begin
                n_fail++;
                $display("FAIL bubble_resume%0d: src %0d erdy %b id %b expected 1/0/0",
                         i, data_ram_gnt_src, evict_req_rdy, evict_req_id);
            end
            @(negedge clk);
        end
        refill_req_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp           = mk(8'(8'h40 + i), 32'hEEEE_0000 + 32'(i));
            evict_req_pld = exp;
            #1;
            n_tests++;
            if (data_ram_gnt_src !== 2'd2 || evict_req_id !== 1'b1 || evict_req_rdy !== 1'b1 ||
                data_ram_req_pld !== exp) begin
                n_fail++;
                $display("FAIL bubble_evict%0d: src %0d id %b erdy %b pld %h expected 2/1/1/%h",
                         i, data_ram_gnt_src, evict_req_id, evict_req_rdy, data_ram_req_pld, exp);
            end
            @(negedge clk);
        end
        evict_req_vld = 1'b0;
    endtask

    task automatic test_evict_stall();
        @(negedge clk);
        evict_req_vld   = 1'b1;
        evict_req_id_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            evict_req_pld = mk(8'(8'h50 + i), 32'hD00D_0000 + 32'(i));
            #1;
            n_tests++;
            if (data_ram_gnt_src !== 2'd2 || evict_req_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_pre%0d: src %0d erdy %b expected 2/1", i, data_ram_gnt_src, evict_req_rdy);
            end
            @(negedge clk);
        end
        data_ram_req_rdy = 1'b0;
        evict_req_pld    = mk(8'h52, 32'hD00D_0002);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (evict_req_rdy !== 1'b0 || data_ram_req_vld !== 1'b1 || dut.r_beat_cnt !== 5'd2) begin
                n_fail++;
                $display("FAIL stall_hold%0d: erdy %b vld %b beat_cnt %0d expected 0/1/2",
                         i, evict_req_rdy, data_ram_req_vld, dut.r_beat_cnt);
            end
            @(negedge clk);
        end
        data_ram_req_rdy = 1'b1;
        for (int i = 2; i < 4; i++) begin
            evict_req_pld = mk(8'(8'h50 + i), 32'hD00D_0000 + 32'(i));
            #1;
            n_tests++;
            if (data_ram_gnt_src !== 2'd2 || evict_req_id !== 1'b1 || evict_req_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_post%0d: src %0d id %b erdy %b expected 2/1/1",
                         i, data_ram_gnt_src, evict_req_id, evict_req_rdy);
            end
            @(negedge clk);
        end
        evict_req_vld = 1'b0;
        core_req_vld  = 1'b1;
        core_req_pld  = mk(8'hC1, 32'hC0C0_0002);
        #1;
        n_tests++;
        if (data_ram_gnt_src !== 2'd3 || evict_req_id !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done_idle: src %0d id %b expected 3/0", data_ram_gnt_src, evict_req_id);
        end
        @(negedge clk);
        core_req_vld = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        evict_req_vld   = 1'b1;
        evict_req_id_in = 1'b1;
        evict_req_pld   = mk(8'h60, 32'h6060_0000);
        @(negedge clk);
        refill_req_vld = 1'b1;
        refill_req_pld = mk(8'h70, 32'h7070_0000);
        #1;
        n_tests++;
        if (data_ram_gnt_src !== 2'd2 || refill_req_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_preempt: src %0d rrdy %b expected 2/0", data_ram_gnt_src, refill_req_rdy);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (data_ram_gnt_src !== 2'd1 || dut.r_beat_cnt !== 5'd0 || evict_req_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: src %0d beat_cnt %0d erdy %b expected 1/0/0",
                     data_ram_gnt_src, dut.r_beat_cnt, evict_req_rdy);
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        evict_req_vld = 1'b0;
        for (int i = 1; i < 4; i++) begin
            refill_req_pld = mk(8'(8'h70 + i), 32'h7070_0000 + 32'(i));
            #1;
            n_tests++;
            if (data_ram_gnt_src !== 2'd1 || refill_req_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL midrst_refill%0d: src %0d rrdy %b expected 1/1", i, data_ram_gnt_src, refill_req_rdy);
            end
            @(negedge clk);
        end
        refill_req_vld = 1'b0;
    endtask

    task automatic test_priority();
        @(negedge clk);
        data_ram_req_rdy = 1'b0;
        refill_req_vld   = 1'b1;
        evict_req_vld    = 1'b1;
        core_req_vld     = 1'b1;
        refill_req_pld   = mk(8'h81, 32'h8181_8181);
        evict_req_pld    = mk(8'h82, 32'h8282_8282);
        core_req_pld     = mk(8'h83, 32'h8383_8383);
        evict_req_id_in  = 1'b1;
        #1;
        n_tests++;
        if (data_ram_gnt_src !== 2'd1 || data_ram_req_pld !== refill_req_pld || refill_req_rdy !== 1'b0 ||
            data_ram_req_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_all: src %0d pld %h rrdy %b vld %b expected 1/%h/0/1",
                     data_ram_gnt_src, data_ram_req_pld, refill_req_rdy, data_ram_req_vld, refill_req_pld);
        end
        refill_req_vld = 1'b0;
        #1;
        n_tests++;
        if (data_ram_gnt_src !== 2'd2 || data_ram_req_pld !== evict_req_pld || evict_req_id !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_evict_core: src %0d pld %h id %b expected 2/%h/1",
                     data_ram_gnt_src, data_ram_req_pld, evict_req_id, evict_req_pld);
        end
        evict_req_vld = 1'b0;
        #1;
        n_tests++;
        if (data_ram_gnt_src !== 2'd3 || data_ram_req_pld !== core_req_pld || evict_req_id !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_core: src %0d pld %h id %b expected 3/%h/0",
                     data_ram_gnt_src, data_ram_req_pld, evict_req_id, core_req_pld);
        end
        core_req_vld = 1'b0;
        #1;
        n_tests++;
        if (data_ram_gnt_src !== 2'd0 || data_ram_req_pld !== '0 || data_ram_req_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_none: src %0d pld %h vld %b expected 0/0/0",
                     data_ram_gnt_src, data_ram_req_pld, data_ram_req_vld);
        end
        @(negedge clk);
        data_ram_req_rdy = 1'b1;
    endtask

    task automatic test_starvation();
        int first_core;
        first_core = 0;
        for (int c = 1; c <= 100 && first_core == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                refill_req_vld = 1'b1;
                evict_req_vld  = 1'b1;
                core_req_vld   = 1'b1;
            end
            #1;
            if (data_ram_gnt_src == 2'd3) first_core = c;
        end
`ifdef L1D_DATA_RAM_ARB_STARVE_EN
        n_tests++;
        if (first_core !== 9) begin
            n_fail++;
            $display("FAIL starve_promote: core first granted cycle %0d expected 9", first_core);
        end
        @(negedge clk); #1;
        n_tests++;
        if (dut.r_starve_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL starve_clear: starve_cnt %0d expected 0", dut.r_starve_cnt);
        end
`else
        n_tests++;
        if (first_core !== 0) begin
            n_fail++;
            $display("FAIL starve_none: core granted cycle %0d expected never in 100", first_core);
        end
`endif
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_refill_burst();
        test_refill_bubble();
        test_evict_stall();
        test_reset_mid_burst();
        test_priority();
        test_starvation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
